// File: rtl/ifid_queue.sv
// ifid_queue: IF/ID decoupling FIFO holding {pc, inst, exccode} entries with
// valid/ready handshakes toward fetch and decode. Flush empties it in one cycle.
// Optional branch delay slot tracking across buffered entries: IFID_DELAY_TRACK_EN.

`ifndef PC_INIT
`define PC_INIT 32'hBFC0_0000
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef EXC_NONE
`define EXC_NONE 5'h10
`endif

module ifid_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned EXC_W  = 5
) (
  input  logic                       cpu_clk_50M,
  input  logic                       cpu_rst_n,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [EXC_W-1:0]           if_exccode,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [EXC_W-1:0]           id_exccode,
  input  logic                       next_in_delay,
  output logic                       id_in_delay,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem  [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  occ_e          occ_state;
  logic          push;
  logic          pop;

  // Occupancy class derived from the registered count only
  always_comb begin
    occ_state = OCC_PARTIAL;
    if (count == '0) begin
      occ_state = OCC_EMPTY;
    end else if (count == FULL_CNT) begin
      occ_state = OCC_FULL;
    end
  end

  assign if_ready  = (occ_state != OCC_FULL);
  assign id_valid  = (occ_state != OCC_EMPTY);
  assign occupancy = count;
  assign push      = if_valid & if_ready & ~flush;
  assign pop       = id_valid & id_ready & ~flush;

  // Pointer and count update; flush wins over push and pop
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; payload needs no reset since emptiness is tracked by count
  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
      exc_mem[wr_ptr]  <= if_exccode;
    end
  end

  // Head outputs, forced to idle values while empty
  always_comb begin
    id_pc      = PC_W'(`PC_INIT);
    id_inst    = INST_W'(`ZERO_WORD);
    id_exccode = EXC_W'(`EXC_NONE);
    if (id_valid) begin
      id_pc      = pc_mem[rd_ptr];
      id_inst    = inst_mem[rd_ptr];
      id_exccode = exc_mem[rd_ptr];
    end
  end

`ifdef IFID_DELAY_TRACK_EN
  logic delay_pend;

  // Remember that the next consumed entry is a delay slot, however far behind it is
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      delay_pend <= 1'b0;
    end else if (flush) begin
      delay_pend <= 1'b0;
    end else if (pop) begin
      delay_pend <= next_in_delay;
    end
  end

  assign id_in_delay = delay_pend & id_valid;
`else
  logic unused_next_in_delay;
  assign unused_next_in_delay = next_in_delay;
  assign id_in_delay          = 1'b0;
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed scenarios plus random traffic against a queue-based
// reference model of the IF/ID buffer (DEPTH=4).

`timescale 1ns/1ps

module tb_ifid_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PC_INIT_V  = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_NONE_V = 5'h10;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
  } ent_t;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  if_exccode;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_exccode;
  logic        next_in_delay;
  logic        id_in_delay;
  logic [2:0]  occupancy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  ent_t model_q[$];
  bit   model_dp;

  ifid_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(5)) dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst_n     (cpu_rst_n),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_exccode    (if_exccode),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_exccode    (id_exccode),
    .next_in_delay (next_in_delay),
    .id_in_delay   (id_in_delay),
    .occupancy     (occupancy)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's view of the queue
  task automatic check_all(input string where);
    bit exp_delay;
    int unsigned n;
    n = model_q.size();
`ifdef IFID_DELAY_TRACK_EN
    exp_delay = model_dp && (n != 0);
`else
    exp_delay = 1'b0;
`endif
    check_eq({where, ".if_ready"},  64'(if_ready),  64'(n != DEPTH));
    check_eq({where, ".id_valid"},  64'(id_valid),  64'(n != 0));
    check_eq({where, ".occupancy"}, 64'(occupancy), 64'(n));
    check_eq({where, ".id_pc"},      64'(id_pc),      64'((n != 0) ? model_q[0].pc   : PC_INIT_V));
    check_eq({where, ".id_inst"},    64'(id_inst),    64'((n != 0) ? model_q[0].inst : 32'h0));
    check_eq({where, ".id_exccode"}, 64'(id_exccode), 64'((n != 0) ? model_q[0].exc  : EXC_NONE_V));
    check_eq({where, ".id_in_delay"}, 64'(id_in_delay), 64'(exp_delay));
  endtask

  // One cycle: check at the falling edge, drive inputs, advance the model
  task automatic step(input string where, input bit fl, input bit iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [4:0] exc, input bit ir, input bit nid);
    ent_t e;
    bit do_push, do_pop;
    @(negedge cpu_clk_50M);
    check_all(where);
    flush = fl; if_valid = iv; if_pc = pc; if_inst = inst; if_exccode = exc;
    id_ready = ir; next_in_delay = nid;
    if (fl) begin
      model_q.delete();
      model_dp = 1'b0;
    end else begin
      do_push = iv && (model_q.size() < DEPTH);
      do_pop  = ir && (model_q.size() > 0);
      if (do_pop) begin
        model_dp = nid;
        void'(model_q.pop_front());
      end
      if (do_push) begin
        e.pc = pc; e.inst = inst; e.exc = exc;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input string where);
    step(where, 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b0, 1'b0);
  endtask

  initial begin
    cpu_rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    if_exccode = EXC_NONE_V; id_ready = 1'b0; next_in_delay = 1'b0;
    model_dp = 1'b0;
    #25;
    check_all("reset");
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;

    // Fill to full with decode stalled; a fifth entry must be refused
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b0, 1'b1, 32'hBFC0_0000 + 32'(4*i), 32'h1000 + 32'(i), EXC_NONE_V, 1'b0, 1'b0);
    end
    // Drain and refill simultaneously; pointers wrap through zero
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b0, 1'b1, 32'hBFC0_0100 + 32'(4*i), 32'h2000 + 32'(i), EXC_NONE_V, 1'b1, 1'b0);
    end
    step("drain", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b0);

    // Exception code travels with its own entry only
    step("exc", 1'b0, 1'b1, 32'h0000_0100, 32'hA, EXC_NONE_V, 1'b0, 1'b0);
    step("exc", 1'b0, 1'b1, 32'h0000_0104, 32'hB, 5'h04,      1'b0, 1'b0);
    step("exc", 1'b0, 1'b1, 32'h0000_0108, 32'hC, EXC_NONE_V, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("exc_pop", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b0);

    // Flush with 3 held, racing a push and a pop: everything is lost
    for (int i = 0; i < 3; i++) begin
      step("pre_flush", 1'b0, 1'b1, 32'h0000_0200 + 32'(4*i), 32'h3000, EXC_NONE_V, 1'b0, 1'b0);
    end
    step("flush", 1'b1, 1'b1, 32'h0000_0300, 32'h3100, EXC_NONE_V, 1'b1, 1'b0);
    idle("post_flush");

    // Delay slot flag follows the entry after a branch across stall cycles
    step("dly", 1'b0, 1'b1, 32'h80, 32'h1, EXC_NONE_V, 1'b0, 1'b0);
    step("dly", 1'b0, 1'b1, 32'h84, 32'h2, EXC_NONE_V, 1'b0, 1'b0);
    step("dly", 1'b0, 1'b1, 32'h88, 32'h3, EXC_NONE_V, 1'b0, 1'b0);
    step("dly_branch", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle("dly_hold");
    step("dly_slot", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b0);
    idle("dly_after");
    step("dly_last", 1'b0, 1'b0, 32'h0, 32'h0, EXC_NONE_V, 1'b1, 1'b0);

    // Asynchronous reset with 2 entries held, away from any clock edge
    step("pre_rst", 1'b0, 1'b1, 32'h0000_0400, 32'h4000, EXC_NONE_V, 1'b0, 1'b0);
    step("pre_rst", 1'b0, 1'b1, 32'h0000_0404, 32'h4001, EXC_NONE_V, 1'b0, 1'b0);
    idle("pre_rst_idle");
    #3;
    cpu_rst_n = 1'b0;
    #1;
    model_q.delete();
    model_dp = 1'b0;
    check_all("async_rst");
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;

    // Random traffic with rare flushes and occasional fetch exceptions
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom, $urandom,
           ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : EXC_NONE_V,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end
    @(negedge cpu_clk_50M);
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
